pci_dma_cycle_split: RTL and testbench
======================================

Name: pci_dma_cycle_split

Overview:
- Bridge-side companion to the CPU byte-enable decode.
- Takes one PCI DMA longword request, given as active-low byte-lane enables, and emits one or two 68040-style sub-cycles (A[1:0], SIZ1/SIZ0, RnW) on the local bus.
- Issues each sub-cycle to the local bus cycle engine with a request/acknowledge handshake and reports completion or error back to the PCI target logic.
- Sits in U712 between the PCI target DMA path and the local bus cycle engine.

Parameters:
- TIMEOUT_CYCLES, 255, number of CLK40 cycles a sub-cycle may wait for CYC_ACK before the request aborts. Range 2..255.
- MAX_RETRY, 7, number of CYC_RETRY events tolerated per request before it aborts with an error.

Ports:
- CLK40  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  synchronous reset, active-high.
- REQ  in  1  start a request; sampled only while in IDLE.
- RnW_IN  in  1  direction of the request: 1 = read.
- nLANE_IN  in  4  active-low lane enables. bit3 = UU (D31:24, A=00), bit2 = UM (A=01), bit1 = LM (A=10), bit0 = LL (A=11).
- CYC_ACK  in  1  bus engine reports the current sub-cycle complete (TA).
- CYC_RETRY  in  1  bus engine requests that the current sub-cycle be re-run.
- BUSY  out  1  high from REQ acceptance until the DONE cycle, inclusive.
- CYC_REQ  out  1  sub-cycle request to the bus engine.
- RnW  out  1  direction of the current sub-cycle.
- A  out  2  A[1:0] of the current sub-cycle.
- SIZ1, SIZ0  out  1 each  68040 size code: 00 = long, 01 = byte, 10 = word.
- LANE_ACT  out  4  active-high lanes of the current sub-cycle, for data steering.
- DONE  out  1  one-cycle pulse when the request finishes.
- ERR  out  1  one-cycle pulse, coincident with DONE, when the request aborts.

Behaviour:
- Reset values: all outputs 0, state IDLE, retry count 0, timeout count 0.
- States: IDLE, WAIT, GAP, FIN.
- IDLE, REQ sampled high at edge N:
  - Latch the remaining mask M = ~nLANE_IN and latch RnW_IN.
  - For a read, force M = 1111. Reads are always a single long cycle.
  - Write with M = 0000: go to FIN. DONE is high in cycle N+1 and CYC_REQ is never asserted.
  - Otherwise: go to WAIT. CYC_REQ is high from N+1 and the attributes are registered.
- Sub-cycle selection from M, upper half first:
  - M = 1111: long, A=00, SIZ=00.
  - Else M[3]&M[2]: word, A=00, SIZ=10.
  - Else M[3]: byte, A=00.
  - Else M[2]: byte, A=01.
  - Else M[1]&M[0]: word, A=10.
  - Else M[1]: byte, A=10.
  - Else M[0]: byte, A=11.
  - LANE_ACT equals the lanes consumed by the selected sub-cycle.
  - At most 2 sub-cycles per request. No misaligned words.
- WAIT: CYC_REQ = 1. A, SIZ, RnW and LANE_ACT are stable for the whole state.
  - CYC_ACK at edge M: clear the consumed lanes from M.
    - If lanes remain: go to GAP. CYC_REQ is 0 in cycle M+1 and the next sub-cycle's attributes load; WAIT resumes at M+2.
    - If none remain: go to FIN.
  - CYC_RETRY, which wins over a simultaneous CYC_ACK: increment the retry count and go to GAP with the same sub-cycle, attributes unchanged.
    - If the retry count exceeds MAX_RETRY: go to FIN with ERR.
  - Timeout: the counter increments every WAIT cycle and clears on entering WAIT.
    - Reaching TIMEOUT_CYCLES with no ACK or RETRY: go to FIN with ERR and clear M.
- FIN: DONE = 1 (plus ERR on abort) for one cycle, CYC_REQ = 0, then IDLE. BUSY falls in the cycle after FIN.
- REQ while not in IDLE is ignored, not queued.
- RESET mid-request: the next cycle is IDLE with all outputs 0. No DONE is generated.
- CYC_ACK or CYC_RETRY outside WAIT is ignored.

Decomposition:
- Shared package:
  - SIZ code constants: SIZ_LONG = 2'b00, SIZ_BYTE = 2'b01, SIZ_WORD = 2'b10.
  - Lane bit index constants: LANE_UU = 3 … LANE_LL = 0.
  - State encoding constants.
- One natural sub-module, pci_lane_pick: purely combinational. Maps the remaining mask to {A, SIZ, LANE_ACT}, so it can be exhaustively checked on all 16 masks.

Test Plan:
- Write, nLANE_IN = 0000, ACK after 3 WAIT cycles:
  - One sub-cycle: A=00, SIZ=00, LANE_ACT=1111.
  - DONE the cycle after ACK, ERR=0.
- Write, nLANE_IN = 0110 (lanes UU and LL):
  - Byte at A=00, then one GAP cycle with CYC_REQ=0, then byte at A=11.
  - DONE after the second ACK.
- Write, nLANE_IN = 1100: single word, A=10, SIZ=10, LANE_ACT=0011.
- Read, nLANE_IN = 1110:
  - Single long, A=00, SIZ=00, RnW=1.
- Write, nLANE_IN = 1111: DONE one cycle after REQ, CYC_REQ never high.
- Error and reset handling:
  - CYC_RETRY with ACK on each WAIT for 8 attempts, MAX_RETRY=7: DONE+ERR on the 8th retry.
  - No ACK for TIMEOUT_CYCLES: DONE+ERR.
  - RESET asserted during WAIT: outputs 0 next cycle, no DONE.

Source files
------------

// File: rtl/pci_dma_cycle_split_pkg.sv
// Shared types and constants for the PCI DMA longword splitter.
// Size codes, lane indices and FSM encoding.
package pci_dma_cycle_split_pkg;

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;

  localparam int LANE_UU = 3;
  localparam int LANE_UM = 2;
  localparam int LANE_LM = 1;
  localparam int LANE_LL = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_GAP  = 2'b10,
    ST_FIN  = 2'b11
  } state_e;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] siz;
    logic [3:0] lane;
  } cycAttr_t;

endpackage

// File: rtl/pci_dma_cycle_split_lane_pick.sv
// Picks the next 68040 sub-cycle from the remaining lane mask.
// Upper half is served first; an empty mask yields all zeros.
module pci_lane_pick
  import pci_dma_cycle_split_pkg::*;
(
  input  logic [3:0] mask,
  output cycAttr_t   attr
);

  always_comb begin
    attr = '0;
    if (&mask) begin
      attr = '{a: 2'b00, siz: SIZ_LONG, lane: 4'b1111};
    end else if (mask[LANE_UU] && mask[LANE_UM]) begin
      attr = '{a: 2'b00, siz: SIZ_WORD, lane: 4'b1100};
    end else if (mask[LANE_UU]) begin
      attr = '{a: 2'b00, siz: SIZ_BYTE, lane: 4'b1000};
    end else if (mask[LANE_UM]) begin
      attr = '{a: 2'b01, siz: SIZ_BYTE, lane: 4'b0100};
    end else if (mask[LANE_LM] && mask[LANE_LL]) begin
      attr = '{a: 2'b10, siz: SIZ_WORD, lane: 4'b0011};
    end else if (mask[LANE_LM]) begin
      attr = '{a: 2'b10, siz: SIZ_BYTE, lane: 4'b0010};
    end else if (mask[LANE_LL]) begin
      attr = '{a: 2'b11, siz: SIZ_BYTE, lane: 4'b0001};
    end
  end

endmodule

// File: rtl/pci_dma_cycle_split.sv
// Splits one PCI DMA longword into at most two local bus sub-cycles.
// Handles ACK/RETRY handshake, retry limit and WAIT timeout.
module pci_dma_cycle_split
  import pci_dma_cycle_split_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 7
) (
  input  logic       CLK40,
  input  logic       RESET,
  input  logic       REQ,
  input  logic       RnW_IN,
  input  logic [3:0] nLANE_IN,
  input  logic       CYC_ACK,
  input  logic       CYC_RETRY,
  output logic       BUSY,
  output logic       CYC_REQ,
  output logic       RnW,
  output logic [1:0] A,
  output logic       SIZ1,
  output logic       SIZ0,
  output logic [3:0] LANE_ACT,
  output logic       DONE,
  output logic       ERR
);

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e state, stateNext;
  logic [3:0] mask, maskNext;
  logic [RW-1:0] retryCnt, retryNext;
  logic [7:0] tmoCnt;
  logic rnwQ;
  logic errQ, errNext;
  cycAttr_t attrQ, nextAttr;

  pci_lane_pick uPick (
    .mask (maskNext),
    .attr (nextAttr)
  );

  always_comb begin
    stateNext = state;
    maskNext  = mask;
    retryNext = retryCnt;
    errNext   = errQ;
    unique case (state)
      ST_IDLE: begin
        if (REQ) begin
          maskNext  = RnW_IN ? 4'b1111 : ~nLANE_IN;
          retryNext = '0;
          errNext   = 1'b0;
          stateNext = (maskNext == 4'b0000) ? ST_FIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (CYC_RETRY) begin
          retryNext = retryCnt + RW'(1);
          if (retryNext > RETRY_MAX) begin
            stateNext = ST_FIN;
            errNext   = 1'b1;
            maskNext  = 4'b0000;
          end else begin
            stateNext = ST_GAP;
          end
        end else if (CYC_ACK) begin
          maskNext  = mask & ~attrQ.lane;
          stateNext = (maskNext == 4'b0000) ? ST_FIN : ST_GAP;
        end else if (tmoCnt == TMO_LAST) begin
          stateNext = ST_FIN;
          errNext   = 1'b1;
          maskNext  = 4'b0000;
        end
      end
      ST_GAP:  stateNext = ST_WAIT;
      ST_FIN:  stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK40) begin
    if (RESET) begin
      state    <= ST_IDLE;
      mask     <= '0;
      retryCnt <= '0;
      tmoCnt   <= '0;
      rnwQ     <= 1'b0;
      errQ     <= 1'b0;
      attrQ    <= '0;
    end else begin
      state    <= stateNext;
      mask     <= maskNext;
      retryCnt <= retryNext;
      errQ     <= errNext;
      // counter restarts on every entry into WAIT
      tmoCnt <= (state == ST_WAIT && stateNext == ST_WAIT)
              ? tmoCnt + 8'd1 : 8'd0;
      attrQ <= (stateNext == ST_WAIT || stateNext == ST_GAP)
             ? nextAttr : '0;
      if (state == ST_IDLE && REQ) begin
        rnwQ <= RnW_IN;
      end else if (stateNext == ST_IDLE) begin
        rnwQ <= 1'b0;
      end
    end
  end

  assign BUSY     = (state != ST_IDLE);
  assign CYC_REQ  = (state == ST_WAIT);
  assign RnW      = rnwQ;
  assign A        = attrQ.a;
  assign SIZ1     = attrQ.siz[1];
  assign SIZ0     = attrQ.siz[0];
  assign LANE_ACT = attrQ.lane;
  assign DONE     = (state == ST_FIN);
  assign ERR      = (state == ST_FIN) && errQ;

endmodule

// File: tb/tb_pci_dma_cycle_split.sv
// Directed scoreboard bench for pci_dma_cycle_split.
// Expected sub-cycles are queued at request time and popped in WAIT.
module tb_pci_dma_cycle_split;
  import pci_dma_cycle_split_pkg::*;

  typedef struct packed {
    logic       rnw;
    logic [1:0] a;
    logic [1:0] siz;
    logic [3:0] lane;
  } sub_t;

  logic       CLK40 = 1'b0;
  logic       RESET = 1'b1;
  logic       REQ = 1'b0;
  logic       RnW_IN = 1'b0;
  logic [3:0] nLANE_IN = 4'hF;
  logic       CYC_ACK = 1'b0;
  logic       CYC_RETRY = 1'b0;
  logic       BUSY, CYC_REQ, RnW, SIZ1, SIZ0, DONE, ERR;
  logic [1:0] A;
  logic [3:0] LANE_ACT;

  int checks = 0;
  int errors = 0;
  sub_t expQ[$];
  logic [12:0] allOut;
  sub_t obsSub;

  assign allOut = {BUSY, CYC_REQ, RnW, A, SIZ1, SIZ0, LANE_ACT, DONE, ERR};
  assign obsSub = '{rnw: RnW, a: A, siz: {SIZ1, SIZ0}, lane: LANE_ACT};

  pci_dma_cycle_split #(
    .TIMEOUT_CYCLES (255),
    .MAX_RETRY      (7)
  ) dut (
    .CLK40     (CLK40),
    .RESET     (RESET),
    .REQ       (REQ),
    .RnW_IN    (RnW_IN),
    .nLANE_IN  (nLANE_IN),
    .CYC_ACK   (CYC_ACK),
    .CYC_RETRY (CYC_RETRY),
    .BUSY      (BUSY),
    .CYC_REQ   (CYC_REQ),
    .RnW       (RnW),
    .A         (A),
    .SIZ1      (SIZ1),
    .SIZ0      (SIZ0),
    .LANE_ACT  (LANE_ACT),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  always #12 CLK40 = ~CLK40;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK40);
  endtask

  task automatic startReq(input logic rnw, input logic [3:0] nl);
    REQ = 1'b1;
    RnW_IN = rnw;
    nLANE_IN = nl;
    step();
    REQ = 1'b0;
  endtask

  // Serves one WAIT phase of n cycles, answering on the last one.
  task automatic subCycle(input string tag, input int n,
                          input logic ack, input logic rty);
    sub_t e;
    if (expQ.size() == 0) begin
      chk({tag, "_sbEmpty"}, 16'(expQ.size()), 16'd1);
      return;
    end
    e = expQ.pop_front();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_req"}, 16'(CYC_REQ), 16'd1);
      chk({tag, "_attr"}, 16'(obsSub), 16'(e));
      if (i == n - 1) begin
        CYC_ACK = ack;
        CYC_RETRY = rty;
      end
      step();
    end
    CYC_ACK = 1'b0;
    CYC_RETRY = 1'b0;
  endtask

  task automatic finCheck(input string tag, input logic err);
    chk({tag, "_done"}, 16'({DONE, ERR, CYC_REQ}), 16'({1'b1, err, 1'b0}));
    step();
    chk({tag, "_idle"}, 16'({BUSY, DONE}), 16'd0);
  endtask

  initial begin
    int n;
    step();
    step();
    chk("resetOut", 16'(allOut), 16'd0);
    RESET = 1'b0;
    step();

    // ACK outside WAIT has no effect
    CYC_ACK = 1'b1;
    step();
    CYC_ACK = 1'b0;
    chk("ackIdle", 16'(allOut), 16'd0);

    // full write, ACK on third WAIT cycle
    expQ.push_back('{1'b0, 2'b00, SIZ_LONG, 4'b1111});
    startReq(1'b0, 4'b0000);
    chk("w0000_busy", 16'(BUSY), 16'd1);
    subCycle("w0000", 3, 1'b1, 1'b0);
    finCheck("w0000", 1'b0);

    // UU + LL: two bytes with one GAP
    expQ.push_back('{1'b0, 2'b00, SIZ_BYTE, 4'b1000});
    expQ.push_back('{1'b0, 2'b11, SIZ_BYTE, 4'b0001});
    startReq(1'b0, 4'b0110);
    subCycle("w0110a", 1, 1'b1, 1'b0);
    chk("w0110_gap", 16'({BUSY, CYC_REQ}), 16'b10);
    chk("w0110_gapAttr", 16'(obsSub), 16'(expQ[0]));
    step();
    subCycle("w0110b", 2, 1'b1, 1'b0);
    finCheck("w0110", 1'b0);

    // low word; REQ held during WAIT must be ignored
    expQ.push_back('{1'b0, 2'b10, SIZ_WORD, 4'b0011});
    startReq(1'b0, 4'b1100);
    REQ = 1'b1;
    nLANE_IN = 4'b0000;
    subCycle("w1100", 2, 1'b1, 1'b0);
    REQ = 1'b0;
    finCheck("w1100", 1'b0);

    // read is always one long cycle
    expQ.push_back('{1'b1, 2'b00, SIZ_LONG, 4'b1111});
    startReq(1'b1, 4'b1110);
    subCycle("r1110", 2, 1'b1, 1'b0);
    finCheck("r1110", 1'b0);

    // empty write finishes without a sub-cycle
    startReq(1'b0, 4'b1111);
    finCheck("w1111", 1'b0);

    // RETRY beats ACK; eighth retry aborts
    for (int k = 0; k < 8; k++) begin
      expQ.push_back('{1'b0, 2'b00, SIZ_LONG, 4'b1111});
    end
    startReq(1'b0, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      subCycle("retry", 1, 1'b1, 1'b1);
      if (k < 7) begin
        chk("retry_gap", 16'({CYC_REQ, obsSub}),
            16'({1'b0, 1'b0, 2'b00, SIZ_LONG, 4'b1111}));
        step();
      end
    end
    finCheck("retry", 1'b1);

    // timeout after 255 WAIT cycles
    expQ.push_back('{1'b0, 2'b01, SIZ_BYTE, 4'b0100});
    startReq(1'b0, 4'b1011);
    if (expQ.size() != 0) begin
      chk("tmo_attr", 16'(obsSub), 16'(expQ.pop_front()));
    end
    n = 0;
    for (int i = 0; i < 400 && CYC_REQ; i++) begin
      n++;
      step();
    end
    chk("tmo_cycles", 16'(n), 16'd255);
    finCheck("tmo", 1'b1);

    // reset mid-WAIT: outputs clear, no DONE
    expQ.push_back('{1'b0, 2'b00, SIZ_LONG, 4'b1111});
    startReq(1'b0, 4'b0000);
    chk("rst_attr", 16'(obsSub), 16'(expQ.pop_front()));
    RESET = 1'b1;
    step();
    chk("rst_out", 16'(allOut), 16'd0);
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_noDone", 16'(allOut), 16'd0);
    end

    chk("sb_empty", 16'(expQ.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
